irig_width_encode: RTL and testbench

//  Transmit-side IRIG-B pulse-width encoder. Accepts one symbol per handshake
//  (ZERO, ONE, MARK) and drives the irigb line with the matching high-time

---
 rtl/irig_width_encode.sv | 140 ++++++++++++++
 tb/tb_irig_width_encode.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irig_width_encode.sv
// IRIG-B pulse-width encoder: one symbol per handshake becomes one fixed-length bit period
// whose high time encodes ZERO/ONE/MARK. A one-entry pending slot allows gapless streaming.
module irig_width_encode #(
  parameter int unsigned CLKS_PER_BIT = 100000,
  parameter int unsigned CYCLES_ZERO  = 20000,
  parameter int unsigned CYCLES_ONE   = 50000,
  parameter int unsigned CYCLES_MARK  = 80000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       sym_ready,
  output logic       irigb,
  output logic       bit_start,
  output logic       underrun,
  output logic       sym_err,
  output logic       busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [CNT_W-1:0] WidthZero = CNT_W'(CYCLES_ZERO);
  localparam logic [CNT_W-1:0] WidthOne  = CNT_W'(CYCLES_ONE);
  localparam logic [CNT_W-1:0] WidthMark = CNT_W'(CYCLES_MARK);
  localparam logic [CNT_W-1:0] LastCnt   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W:0]   CntStep   = (CNT_W + 1)'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_width_q, pend_width_d;
  logic             irigb_q, irigb_d;
  logic             bit_start_q, bit_start_d;
  logic             underrun_q, underrun_d;
  logic             sym_err_q, sym_err_d;

  logic             accept;
  logic             load;
  logic [CNT_W-1:0] sym_width;
  logic [CNT_W:0]   cnt_next_wide;

  assign accept        = sym_valid & ~pend_valid_q;
  assign cnt_next_wide = {1'b0, cnt_q} + CntStep;

  // Reserved code 11 falls through to the ZERO width.
  always_comb begin
    sym_width = WidthZero;
    case (sym)
      2'b01:   sym_width = WidthOne;
      2'b10:   sym_width = WidthMark;
      default: sym_width = WidthZero;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    width_d      = width_q;
    pend_valid_d = pend_valid_q;
    pend_width_d = pend_width_q;
    irigb_d      = 1'b0;
    bit_start_d  = 1'b0;
    underrun_d   = 1'b0;
    sym_err_d    = 1'b0;
    load         = 1'b0;

    if (accept) begin
      pend_valid_d = 1'b1;
      pend_width_d = sym_width;
      sym_err_d    = (sym == 2'b11);
    end

    case (state_q)
      StIdle: begin
        load = pend_valid_q;
      end
      StRun: begin
        if (cnt_q == LastCnt) begin
          if (pend_valid_q) begin
            load = 1'b1;
          end else begin
            state_d    = StIdle;
            cnt_d      = '0;
            underrun_d = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          // irigb is registered, so decide the level for the cycle where cnt becomes cnt+1.
          irigb_d = (cnt_next_wide < {1'b0, width_q});
        end
      end
      default: state_d = StIdle;
    endcase

    // Load never coincides with accept: it needs the pending slot full, accept needs it empty.
    if (load) begin
      state_d      = StRun;
      cnt_d        = '0;
      width_d      = pend_width_q;
      pend_valid_d = 1'b0;
      irigb_d      = 1'b1;
      bit_start_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      width_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_width_q <= '0;
      irigb_q      <= 1'b0;
      bit_start_q  <= 1'b0;
      underrun_q   <= 1'b0;
      sym_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      width_q      <= width_d;
      pend_valid_q <= pend_valid_d;
      pend_width_q <= pend_width_d;
      irigb_q      <= irigb_d;
      bit_start_q  <= bit_start_d;
      underrun_q   <= underrun_d;
      sym_err_q    <= sym_err_d;
    end
  end

  assign sym_ready = ~pend_valid_q;
  assign irigb     = irigb_q;
  assign bit_start = bit_start_q;
  assign underrun  = underrun_q;
  assign sym_err   = sym_err_q;
  assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_irig_width_encode.sv
// Bench for irig_width_encode: a driver pushes expected high widths per accepted symbol,
// a negedge monitor measures each high pulse and pops/compares.
module tb_irig_width_encode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = 2'b00;
  logic       sym_ready, irigb, bit_start, underrun, sym_err, busy;

  irig_width_encode #(
    .CLKS_PER_BIT(100),
    .CYCLES_ZERO (20),
    .CYCLES_ONE  (50),
    .CYCLES_MARK (80),
    .CNT_W       (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sym_valid(sym_valid),
    .sym      (sym),
    .sym_ready(sym_ready),
    .irigb    (irigb),
    .bit_start(bit_start),
    .underrun (underrun),
    .sym_err  (sym_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  int rise_q[$];
  int n_bs = 0, n_ur = 0, n_se = 0, n_hi = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int width_of(input logic [1:0] s);
    case (s)
      2'b01:   return 50;
      2'b10:   return 80;
      default: return 20;
    endcase
  endfunction

  // Monitor: measures every high pulse and compares it with the next expected width.
  logic mon_prev = 1'b0;
  int   mon_hi = 0;
  always @(negedge clk) begin
    if (rst) begin
      mon_prev = 1'b0;
      mon_hi   = 0;
      exp_q.delete();
    end else begin
      if (bit_start) n_bs++;
      if (underrun) n_ur++;
      if (sym_err) n_se++;
      if (irigb) n_hi++;
      if (bit_start || (irigb && !mon_prev))
        chk("bit_start_at_rise", int'(bit_start), int'(irigb && !mon_prev));
      if (irigb && !mon_prev) begin
        rise_q.push_back(cyc);
        mon_hi = 1;
      end else if (irigb) begin
        mon_hi++;
      end
      if (!irigb && mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL high_width: got a %0d-cycle pulse, required no bit", mon_hi);
        end else begin
          chk("high_width", mon_hi, exp_q.pop_front());
        end
      end
      mon_prev = irigb;
    end
  end

  // Driver actions happen 1 ns after the falling edge, clear of the monitor.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    int b = 0;
    sym_valid = 1'b1;
    sym       = s;
    while (!sym_ready && b < 1000) begin
      step(1);
      b++;
    end
    if (b >= 1000) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    exp_q.push_back(width_of(s));
  endtask

  task automatic wait_idle();
    int b = 0;
    step(1);
    while (busy && b < 1000) begin
      step(1);
      b++;
    end
    if (b >= 1000) chk("idle_timeout", 0, 1);
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  int bs0, ur0, se0, hi0, r0;

  initial begin
    // 1: reset and idle
    step(4);
    chk("rst_irigb", int'(irigb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sym_ready", int'(sym_ready), 1);
    rst = 1'b0;
    step(1);
    chk("idle_bit_start", int'(bit_start), 0);
    chk("idle_underrun", int'(underrun), 0);
    chk("idle_sym_err", int'(sym_err), 0);
    bs0 = n_bs; ur0 = n_ur; se0 = n_se; hi0 = n_hi;
    step(300);
    chk("idle_high_cycles", n_hi - hi0, 0);
    chk("idle_pulses", (n_bs - bs0) + (n_ur - ur0) + (n_se - se0), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_sym_ready", int'(sym_ready), 1);

    // 2: single ONE, cycle-accurate latency and underrun
    bs0 = n_bs; ur0 = n_ur;
    send(2'b01);
    chk("one_pend_ready", int'(sym_ready), 0);
    chk("one_pend_busy", int'(busy), 0);
    step(1);
    chk("one_lat_low", int'(irigb), 0);
    step(1);
    chk("one_first_high", int'(irigb), 1);
    chk("one_bit_start", int'(bit_start), 1);
    chk("one_busy", int'(busy), 1);
    chk("one_ready_again", int'(sym_ready), 1);
    step(49);
    chk("one_last_high", int'(irigb), 1);
    step(1);
    chk("one_first_low", int'(irigb), 0);
    step(49);
    chk("one_end_busy", int'(busy), 1);
    chk("one_end_no_underrun", int'(underrun), 0);
    step(1);
    chk("one_underrun", int'(underrun), 1);
    chk("one_idle", int'(busy), 0);
    step(1);
    chk("one_underrun_single", int'(underrun), 0);
    chk("one_bs_count", n_bs - bs0, 1);
    chk("one_ur_count", n_ur - ur0, 1);

    // 3: back-to-back stream MARK, ZERO, ONE, ZERO
    bs0 = n_bs; ur0 = n_ur; r0 = rise_q.size();
    send(2'b10);
    send(2'b00);
    send(2'b01);
    send(2'b00);
    wait_idle();
    chk("stream_bs_count", n_bs - bs0, 4);
    chk("stream_ur_count", n_ur - ur0, 1);
    chk("stream_rises", rise_q.size() - r0, 4);
    if (rise_q.size() - r0 == 4)
      for (int i = 0; i < 3; i++)
        chk("stream_period", rise_q[r0+i+1] - rise_q[r0+i], 100);

    // 4: held valid while not ready
    bs0 = n_bs; r0 = rise_q.size();
    send(2'b00);
    send(2'b10);
    sym_valid = 1'b1;
    sym       = 2'b01;
    step(10);
    chk("hold_not_ready", int'(sym_ready), 0);
    send(2'b01);
    wait_idle();
    chk("hold_bs_count", n_bs - bs0, 3);
    if (rise_q.size() - r0 == 3)
      chk("hold_period", rise_q[r0+2] - rise_q[r0+1], 100);
    else
      chk("hold_rises", rise_q.size() - r0, 3);

    // 5: reserved code
    se0 = n_se;
    send(2'b11);
    chk("err_pulse", int'(sym_err), 1);
    step(1);
    chk("err_pulse_hold", int'(sym_err), 1);
    step(1);
    chk("err_pulse_end", int'(sym_err), 0);
    wait_idle();
    chk("err_count", n_se - se0, 1);

    // 6: reset mid-MARK with a symbol pending
    send(2'b10);
    step(2);
    chk("abort_rise", int'(irigb), 1);
    send(2'b01);
    step(30);
    chk("abort_pre_high", int'(irigb), 1);
    chk("abort_pre_pending", int'(sym_ready), 0);
    rst = 1'b1;
    step(1);
    chk("abort_irigb", int'(irigb), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(sym_ready), 1);
    step(3);
    rst = 1'b0;
    bs0 = n_bs; ur0 = n_ur; hi0 = n_hi;
    step(300);
    chk("abort_no_high", n_hi - hi0, 0);
    chk("abort_no_bit", n_bs - bs0, 0);
    chk("abort_no_underrun", n_ur - ur0, 0);
    chk("abort_idle", int'(busy), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
